board_ctrl: RTL and testbench
=============================

Name: board_ctrl

Overview:
- Game-board register and turn/outcome controller for the 3x3 tic-tac-toe datapath.
- Accepts move strobes and holds the nine 2-bit cell registers pos1..pos9. These feed the no-space detector and the win detectors combinationally.
- Consumes no_space, win_x and win_o from those detectors to decide game end, and alternates turns.
- Cell encoding is fixed for the whole datapath: 2'b00 empty, 2'b01 X, 2'b10 O, 2'b11 never written.

Parameters:
- FIRST_PLAYER, 0, player to move after reset/new game (0 = X, 1 = O).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears the board and all state.
- new_game  input  1  1-cycle strobe; clears the board and restarts, same effect as reset.
- move_valid  input  1  1-cycle strobe; the current player places a mark at move_pos.
- move_pos  input  4  target cell, 1..9 row-major; 0 and 10..15 are invalid.
- no_space  input  1  from the no-space detector; all nine cells are occupied.
- win_x  input  1  from the win detector; X has three in a row.
- win_o  input  1  from the win detector; O has three in a row.
- pos1..pos9  output  2 each  registered cell contents.
- turn  output  1  player to move (0 = X, 1 = O).
- ready  output  1  high in PLAY state; a move is accepted this cycle.
- illegal  output  1  1-cycle pulse when a move is rejected.
- game_over  output  1  high in OVER state.
- winner  output  2  00 none, 01 X, 10 O, 11 draw; valid while game_over is high.
- move_count  output  4  accepted moves this game, 0..9.

Behaviour:
- Reset (and new_game) values:
  - pos1..pos9 = 00, turn = FIRST_PLAYER, move_count = 0, winner = 00.
  - illegal = 0, game_over = 0, state = PLAY, ready = 1.
- new_game has priority over every other input. A move_valid in the same cycle is dropped.
- States:
  - PLAY: ready = 1.
    - On move_valid with move_pos in 1..9 and the target cell 00: write the cell (01 if turn = 0, else 10), increment move_count, go to CHECK.
    - On move_valid with move_pos out of range or the cell non-zero: illegal = 1 for the next cycle only. No board, turn or count change; stay in PLAY.
  - CHECK: ready = 0; lasts exactly one cycle. The detector inputs now reflect the updated registered board. Priority order:
    - win_x -> OVER, winner = 01.
    - else win_o -> OVER, winner = 10.
    - else no_space -> OVER, winner = 11.
    - else toggle turn and go to PLAY.
  - OVER: ready = 0, game_over = 1. Board, winner and move_count are held. Only reset or new_game leaves this state.
- move_valid in CHECK or OVER is ignored silently: no illegal pulse, no change.
- Latency:
  - A move accepted at edge N is visible on pos* after edge N.
  - The outcome (game_over/winner or turn toggle) is registered at edge N+1.
  - ready returns no earlier than after edge N+1.
- A win on the 9th move reports the winner, not a draw.
- win_x and win_o together (not reachable in legal play) resolve to X.
- move_count saturates at 9 and never wraps.
- Detector inputs are sampled only in CHECK.
- Reset or new_game mid-game or in CHECK takes effect at the next edge, with no residual illegal pulse.

Test Plan:
- Reset, then moves X@1, O@4, X@2, O@5, X@3, each followed by idle cycles:
  - game_over rises one cycle after the X@3 edge, with winner = 01 and move_count = 5.
  - pos1..3 = 01, pos4..5 = 10.
- Move to an occupied cell (X@5, then O@5):
  - illegal pulses for exactly 1 cycle; pos5 stays 01, turn stays 1, move_count = 1.
- move_pos = 0 and move_pos = 12 while in PLAY: an illegal pulse for each, board unchanged.
- Full-board draw sequence X5, O1, X9, O3, X2, O8, X7, O4, X6: after the 9th move no_space = 1 and no win, so winner = 11, game_over = 1, move_count = 9.
- Winning 9th move (detector asserts win_x and no_space together): winner = 01, not 11.
- Control overrides:
  - new_game asserted with move_valid in the same cycle: the board reads all 00 and move_count = 0.
  - reset asserted in CHECK: next cycle is PLAY, turn = FIRST_PLAYER.
  - move_valid during OVER: no change and no illegal pulse.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe board registers and the turn/outcome controller.
// It holds the nine 2-bit cells and accepts one move at a time. After each
// accepted move it spends one CHECK cycle so that the external detectors can
// see the updated board. It then either ends the game or hands the turn over.
// Cell encoding: 2'b00 empty, 2'b01 X, 2'b10 O.
module board_ctrl #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       no_space,
    input  logic       win_x,
    input  logic       win_o,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic       ready,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] move_count
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_OVER  = 2'b10
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_X      = 2'b01;
    localparam logic [1:0] WIN_O      = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    // Registered state. Cell k (1..9) lives at cells_r[k-1].
    state_t          state_r;
    logic [8:0][1:0] cells_r;
    logic            turn_r;
    logic [3:0]      count_r;
    logic [1:0]      winner_r;
    logic            illegal_r;

    // Next-state values.
    state_t          state_s;
    logic [8:0][1:0] cells_s;
    logic            turn_s;
    logic [3:0]      count_s;
    logic [1:0]      winner_s;
    logic            illegal_s;

    // Move decoding.
    logic            pos_ok_s;
    logic [3:0]      idx_s;
    logic [1:0]      target_s;

    // A cell index is legal only in 1..9. Outside that range the target is
    // treated as occupied, so the move is rejected.
    function automatic logic pos_in_range(input logic [3:0] p);
        return (p >= 4'd1) && (p <= 4'd9);
    endfunction

    // Decode the requested cell and read its current contents.
    always_comb begin
        pos_ok_s = pos_in_range(move_pos);
        idx_s    = move_pos - 4'd1;
        if (pos_ok_s) begin
            target_s = cells_r[idx_s];
        end else begin
            target_s = 2'b11;
        end
    end

    // Next-state and next-output logic. new_game overrides everything else.
    always_comb begin
        state_s   = state_r;
        cells_s   = cells_r;
        turn_s    = turn_r;
        count_s   = count_r;
        winner_s  = winner_r;
        illegal_s = 1'b0;
        if (new_game) begin
            state_s  = ST_PLAY;
            cells_s  = '0;
            turn_s   = FIRST_PLAYER;
            count_s  = 4'd0;
            winner_s = WIN_NONE;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (move_valid) begin
                        if (target_s == CELL_EMPTY) begin
                            cells_s[idx_s] = turn_r ? CELL_O : CELL_X;
                            if (count_r != 4'd9) begin
                                count_s = count_r + 4'd1;
                            end else begin
                                count_s = count_r;
                            end
                            state_s = ST_CHECK;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_CHECK: begin
                    // X is checked first, so a simultaneous report resolves to X.
                    // A win is checked before a full board, so a winning ninth
                    // move is not reported as a draw.
                    if (win_x) begin
                        winner_s = WIN_X;
                        state_s  = ST_OVER;
                    end else if (win_o) begin
                        winner_s = WIN_O;
                        state_s  = ST_OVER;
                    end else if (no_space) begin
                        winner_s = WIN_DRAW;
                        state_s  = ST_OVER;
                    end else begin
                        turn_s  = ~turn_r;
                        state_s = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    state_s = ST_OVER;
                end
                default: begin
                    state_s = ST_PLAY;
                end
            endcase
        end
    end

    // State and board registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_PLAY;
            cells_r   <= '0;
            turn_r    <= FIRST_PLAYER;
            count_r   <= 4'd0;
            winner_r  <= WIN_NONE;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cells_r   <= cells_s;
            turn_r    <= turn_s;
            count_r   <= count_s;
            winner_r  <= winner_s;
            illegal_r <= illegal_s;
        end
    end

    assign pos1       = cells_r[0];
    assign pos2       = cells_r[1];
    assign pos3       = cells_r[2];
    assign pos4       = cells_r[3];
    assign pos5       = cells_r[4];
    assign pos6       = cells_r[5];
    assign pos7       = cells_r[6];
    assign pos8       = cells_r[7];
    assign pos9       = cells_r[8];
    assign turn       = turn_r;
    assign ready      = (state_r == ST_PLAY);
    assign game_over  = (state_r == ST_OVER);
    assign winner     = winner_r;
    assign move_count = count_r;
    assign illegal    = illegal_r;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl. The bench models the external win and
// no-space detectors from the board outputs. Override bits let it inject
// detector reports that cannot arise in legal play.
module tb_board_ctrl;

    logic       clk = 1'b0;
    logic       reset, new_game, move_valid;
    logic [3:0] move_pos;
    logic       no_space, win_x, win_o;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       turn, ready, illegal, game_over;
    logic [1:0] winner;
    logic [3:0] move_count;
    logic       ovr_wx, ovr_wo;

    int checks = 0;
    int errors = 0;

    board_ctrl #(.FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos),
        .no_space(no_space), .win_x(win_x), .win_o(win_o),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .turn(turn), .ready(ready), .illegal(illegal),
        .game_over(game_over), .winner(winner), .move_count(move_count)
    );

    always #5 clk = ~clk;

    wire [17:0] board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    // Reference model of the external detectors: eight lines and full board.
    function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
        logic [1:0] c [9];
        for (int k = 0; k < 9; k++) c[k] = b[2*k +: 2];
        return (c[0] == m && c[1] == m && c[2] == m) || (c[3] == m && c[4] == m && c[5] == m) ||
               (c[6] == m && c[7] == m && c[8] == m) || (c[0] == m && c[3] == m && c[6] == m) ||
               (c[1] == m && c[4] == m && c[7] == m) || (c[2] == m && c[5] == m && c[8] == m) ||
               (c[0] == m && c[4] == m && c[8] == m) || (c[2] == m && c[4] == m && c[6] == m);
    endfunction

    function automatic logic full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int k = 0; k < 9; k++) if (b[2*k +: 2] == 2'b00) f = 1'b0;
        return f;
    endfunction

    assign win_x    = has_line(board, 2'b01) | ovr_wx;
    assign win_o    = has_line(board, 2'b10) | ovr_wo;
    assign no_space = full(board);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a move strobe for one edge. On return, that edge has passed.
    task automatic move(input logic [3:0] p);
        move_valid = 1'b1;
        move_pos   = p;
        step();
        move_valid = 1'b0;
        move_pos   = 4'd0;
    endtask

    // An accepted move followed by its CHECK cycle.
    task automatic play(input logic [3:0] p);
        move(p);
        step();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
        ovr_wx = 1'b0; ovr_wo = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state.
        chk("rst_board", 32'(board), 32'h0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // A detector report during PLAY is ignored.
        ovr_wx = 1'b1;
        step();
        ovr_wx = 1'b0;
        chk("play_ignores_det", 32'(game_over), 32'd0);

        // X wins along the top row: X1 O4 X2 O5 X3.
        play(4'd1);
        chk("turn_after_x", 32'(turn), 32'd1);
        play(4'd4);
        play(4'd2);
        play(4'd5);
        move(4'd3);
        chk("check_ready_low", 32'(ready), 32'd0);
        chk("check_not_over", 32'(game_over), 32'd0);
        chk("check_pos3_visible", 32'(pos3), 32'd1);
        step();
        chk("xwin_over", 32'(game_over), 32'd1);
        chk("xwin_winner", 32'(winner), 32'd1);
        chk("xwin_count", 32'(move_count), 32'd5);
        chk("xwin_board", 32'(board), 32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}));

        // A move during OVER changes nothing and raises no illegal pulse.
        move(4'd6);
        chk("over_move_illegal", 32'(illegal), 32'd0);
        chk("over_move_board", 32'(board), 32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}));
        chk("over_move_count", 32'(move_count), 32'd5);
        chk("over_hold", 32'(game_over), 32'd1);

        // new_game with a simultaneous move: the move is dropped.
        new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd3;
        step();
        new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
        chk("ng_board", 32'(board), 32'h0);
        chk("ng_count", 32'(move_count), 32'd0);
        chk("ng_ready", 32'(ready), 32'd1);
        chk("ng_winner", 32'(winner), 32'd0);
        chk("ng_turn", 32'(turn), 32'd0);

        // Occupied cell: X@5, then O@5 is rejected.
        play(4'd5);
        move(4'd5);
        chk("occ_illegal", 32'(illegal), 32'd1);
        step();
        chk("occ_pulse_1cyc", 32'(illegal), 32'd0);
        chk("occ_pos5", 32'(pos5), 32'd1);
        chk("occ_turn", 32'(turn), 32'd1);
        chk("occ_count", 32'(move_count), 32'd1);
        chk("occ_ready", 32'(ready), 32'd1);

        // Out-of-range cells 0 and 12.
        move(4'd0);
        chk("pos0_illegal", 32'(illegal), 32'd1);
        step();
        move(4'd12);
        chk("pos12_illegal", 32'(illegal), 32'd1);
        chk("range_board", 32'(board), 32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00}));
        chk("range_count", 32'(move_count), 32'd1);

        // Reset asserted in CHECK.
        move(4'd1);
        chk("pre_rst_check", 32'(ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_check_ready", 32'(ready), 32'd1);
        chk("rst_check_turn", 32'(turn), 32'd0);
        chk("rst_check_count", 32'(move_count), 32'd0);
        chk("rst_check_illegal", 32'(illegal), 32'd0);
        step();
        chk("rst_check_stay", 32'(ready), 32'd1);

        // Full-board draw: X5 O1 X9 O3 X2 O8 X7 O4 X6.
        play(4'd5); play(4'd1); play(4'd9); play(4'd3); play(4'd2);
        play(4'd8); play(4'd7); play(4'd4); play(4'd6);
        chk("draw_winner", 32'(winner), 32'd3);
        chk("draw_over", 32'(game_over), 32'd1);
        chk("draw_count", 32'(move_count), 32'd9);

        // X wins on the 9th move while the board is full: X1 O2 X3 O4 X6 O5 X8 O7 X9.
        do_new_game();
        play(4'd1); play(4'd2); play(4'd3); play(4'd4); play(4'd6);
        play(4'd5); play(4'd8); play(4'd7);
        chk("win9_not_yet", 32'(game_over), 32'd0);
        play(4'd9);
        chk("win9_winner", 32'(winner), 32'd1);
        chk("win9_count", 32'(move_count), 32'd9);

        // O wins along the middle row: X1 O4 X2 O5 X7 O6.
        do_new_game();
        play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd7); play(4'd6);
        chk("owin_winner", 32'(winner), 32'd2);
        chk("owin_count", 32'(move_count), 32'd6);

        // Both detectors report a win: X takes priority.
        do_new_game();
        ovr_wx = 1'b1; ovr_wo = 1'b1;
        play(4'd1);
        ovr_wx = 1'b0; ovr_wo = 1'b0;
        chk("both_winner", 32'(winner), 32'd1);
        chk("both_over", 32'(game_over), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
